// File: rtl/join_arb_pkg.sv
// Shared types and defaults for the join_arb round-robin adder scheduler.
package join_arb_pkg;

    localparam int unsigned SIZE_DEF = 8;
    localparam int unsigned N_DEF    = 4;

    // Tag width never drops below one bit, so a 2-requester build still has a tag.
    function automatic int unsigned tag_w(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

    localparam int unsigned TAG_W_DEF = tag_w(N_DEF);

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [SIZE_DEF-1:0]  sum;
    } entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/join_arb_buf.sv
// Two-entry registered valid/retry buffer; the head is always a flop output.
module join_arb_buf
    import join_arb_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         dinValid,
    output logic         dinRetry,
    output logic [W-1:0] q,
    output logic         qValid,
    input  logic         qRetry
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push;
    logic         pop;

    // Full blocks a push even when the head leaves this cycle: no retry-to-retry path.
    assign dinRetry = (state_q == BUF_FULL);
    assign qValid   = (state_q != BUF_EMPTY);
    assign q        = head_q;
    assign push     = dinValid && !dinRetry;
    assign pop      = qValid && !qRetry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = din;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = din;
                        state_d = BUF_FULL;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    2'b11: head_d  = din;
                    default: ;
                endcase
            end
            BUF_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

endmodule

// File: rtl/join_arb.sv
// Round-robin scheduler sharing one adder among N requesters; results are
// queued with their requester tag and steered back to the originating sink.
module join_arb
    import join_arb_pkg::*;
#(
    parameter int unsigned Size = SIZE_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned TagW = tag_w(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*Size-1:0] inp_a,
    input  logic [N*Size-1:0] inp_b,
    input  logic [N-1:0]      inp_valid,
    output logic [N-1:0]      inp_retry,
    output logic [Size-1:0]   sum,
    output logic [TagW-1:0]   sum_tag,
    output logic [N-1:0]      sum_valid,
    input  logic [N-1:0]      sum_retry
);

    localparam int unsigned EntW = TagW + Size;

    logic [TagW-1:0] ptr_q, ptr_d;
    logic            can_accept;
    logic            gnt_any;
    logic [TagW-1:0] gnt_idx;
    logic [N-1:0]    gnt_oh;
    int unsigned     scan_idx;
    logic [TagW-1:0] cand;
    logic [Size-1:0] sel_a, sel_b, sum_next;
    logic [EntW-1:0] push_ent, head_ent;
    logic            buf_full, head_valid, head_retry;
    logic [TagW-1:0] head_tag;

    // Gating on reset keeps every requester retried while reset is held.
    assign can_accept = reset && !buf_full;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            cand = TagW'(scan_idx);
            if (can_accept && !gnt_any && inp_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    end

    assign inp_retry = ~gnt_oh;

    assign sel_a    = inp_a[32'(gnt_idx)*Size +: Size];
    assign sel_b    = inp_b[32'(gnt_idx)*Size +: Size];
    assign sum_next = sel_a + sel_b;
    assign push_ent = {gnt_idx, sum_next};

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == TagW'(N - 1)) ? '0 : gnt_idx + TagW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    join_arb_buf #(
        .W(EntW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .din     (push_ent),
        .dinValid(gnt_any),
        .dinRetry(buf_full),
        .q       (head_ent),
        .qValid  (head_valid),
        .qRetry  (head_retry)
    );

    assign head_tag   = head_ent[EntW-1:Size];
    assign head_retry = sum_retry[head_tag];
    assign sum        = head_ent[Size-1:0];
    assign sum_tag    = head_tag;
    assign sum_valid  = head_valid ? (N'(1) << head_tag) : '0;

endmodule

// File: tb/tb_join_arb.sv
// Directed and randomized checks of join_arb against a queue-based reference model.
module tb_join_arb;
    import join_arb_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned Size = 8;
    localparam int unsigned TagW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*Size-1:0] inp_a;
    logic [N*Size-1:0] inp_b;
    logic [N-1:0]      inp_valid;
    logic [N-1:0]      inp_retry;
    logic [Size-1:0]   sum;
    logic [TagW-1:0]   sum_tag;
    logic [N-1:0]      sum_valid;
    logic [N-1:0]      sum_retry;

    int checks = 0;
    int errors = 0;

    entry_t      mq[$];
    int unsigned mptr = 0;
    int          last_grant = -1;

    join_arb #(
        .Size(Size),
        .N   (N),
        .TagW(TagW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inp_a    (inp_a),
        .inp_b    (inp_b),
        .inp_valid(inp_valid),
        .inp_retry(inp_retry),
        .sum      (sum),
        .sum_tag  (sum_tag),
        .sum_valid(sum_valid),
        .sum_retry(sum_retry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        inp_a[i*Size +: Size] = a;
        inp_b[i*Size +: Size] = b;
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        int          g;
        int unsigned idx;
        logic [N-1:0] er;
        logic [7:0]  s;
        @(negedge clk);
        g = -1;
        if (reset && mq.size() < 2) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (g < 0 && inp_valid[idx]) g = int'(idx);
            end
        end
        er = '1;
        if (g >= 0) er[g] = 1'b0;
        chk("model_inp_retry", 32'(inp_retry), 32'(er));
        if (mq.size() > 0) begin
            chk("model_sum_valid", 32'(sum_valid), 32'(1) << mq[0].tag);
            chk("model_sum", 32'(sum), 32'(mq[0].sum));
            chk("model_sum_tag", 32'(sum_tag), 32'(mq[0].tag));
        end else begin
            chk("model_sum_valid_empty", 32'(sum_valid), 32'(0));
        end
        last_grant = g;
        if (reset) begin
            if (mq.size() > 0 && !sum_retry[mq[0].tag]) void'(mq.pop_front());
            if (g >= 0) begin
                s = inp_a[g*Size +: Size] + inp_b[g*Size +: Size];
                mq.push_back('{tag: 2'(g), sum: s});
                mptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        inp_a     = '0;
        inp_b     = '0;
        inp_valid = '0;
        sum_retry = '0;
        #2;
        chk("rst_sum_valid", 32'(sum_valid), 32'(0));
        chk("rst_inp_retry", 32'(inp_retry), 32'hF);
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_sum_tag", 32'(sum_tag), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single request from requester 1.
        set_req(1, 8'h10, 8'h22);
        inp_valid = 4'b0010;
        #1;
        chk("single_retry1", 32'(inp_retry[1]), 32'(0));
        cycle();
        chk("single_sum", 32'(sum), 32'h32);
        chk("single_tag", 32'(sum_tag), 32'(1));
        chk("single_valid", 32'(sum_valid), 32'b0010);
        inp_valid = '0;
        cycle();

        // Carry is discarded.
        set_req(0, 8'hF0, 8'h20);
        inp_valid = 4'b0001;
        cycle();
        chk("wrap_sum", 32'(sum), 32'h10);
        chk("wrap_tag", 32'(sum_tag), 32'(0));
        inp_valid = '0;
        cycle();

        // All requesters valid; pointer sits at 1 after the two grants above.
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), 8'(i + 3));
        inp_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", 32'(inp_retry), 32'(~(4'b0001 << ((1 + c) % 4)) & 4'hF));
            cycle();
            chk("rr_tag", 32'(sum_tag), 32'((1 + c) % 4));
        end
        inp_valid = '0;
        cycle();
        cycle();

        // Back-pressure fills the buffer; count==2 blocks even while the head pops.
        sum_retry = 4'b1111;
        set_req(2, 8'h01, 8'h02);
        set_req(3, 8'h03, 8'h04);
        inp_valid = 4'b1100;
        cycle();
        cycle();
        #1;
        chk("bp_full_retry", 32'(inp_retry), 32'hF);
        chk("bp_head_tag", 32'(sum_tag), 32'(2));
        chk("bp_head_valid", 32'(sum_valid), 32'b0100);
        cycle();
        sum_retry = 4'b1011;
        #1;
        chk("bp_pop_still_full", 32'(inp_retry), 32'hF);
        cycle();
        #1;
        chk("bp_stall_tag", 32'(sum_tag), 32'(3));
        chk("bp_stall_valid", 32'(sum_valid), 32'b1000);
        chk("bp_accept_again", 32'(inp_retry), 32'b1011);
        cycle();
        cycle();
        chk("bp_hol_tag", 32'(sum_tag), 32'(3));
        inp_valid = '0;
        sum_retry = '0;
        repeat (3) cycle();

        // Simultaneous push and pop with one entry held.
        set_req(1, 8'h05, 8'h06);
        inp_valid = 4'b0010;
        cycle();
        set_req(0, 8'h40, 8'h02);
        inp_valid = 4'b0001;
        #1;
        chk("pp_grant0", 32'(inp_retry), 32'b1110);
        cycle();
        chk("pp_new_head_tag", 32'(sum_tag), 32'(0));
        chk("pp_new_head_sum", 32'(sum), 32'h42);
        chk("pp_one_entry", 32'(sum_valid), 32'b0001);
        inp_valid = '0;
        cycle();

        // Reset asserted between edges with the buffer full.
        sum_retry = 4'b1111;
        inp_valid = 4'b1111;
        cycle();
        cycle();
        inp_valid = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_sum_valid", 32'(sum_valid), 32'(0));
        chk("mrst_inp_retry", 32'(inp_retry), 32'hF);
        mq.delete();
        mptr = 0;
        cycle();
        reset = 1'b1;
        sum_retry = '0;
        inp_valid = 4'b1111;
        #1;
        chk("mrst_first_grant", 32'(inp_retry), 32'b1110);
        cycle();

        // Randomized traffic; a pending requester keeps its operands until granted.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!inp_valid[i] || last_grant == i) begin
                    inp_valid[i] = ($urandom_range(0, 9) < 6);
                    set_req(i, 8'($urandom), 8'($urandom));
                end
            end
            for (int i = 0; i < N; i++) sum_retry[i] = ($urandom_range(0, 9) < 3);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/join_arb.md
Name: join_arb

Overview:
- Round-robin scheduler that shares one 8-bit adder among N requesters.
- Each requester offers an operand pair (a, b) on a valid/retry channel.
- The block grants one requester per cycle, adds its operands, and queues {tag, sum} in a 2-entry registered output buffer.
- The buffer head is steered to the originating requester's result channel.
- Sits between multiple producers and a single shared add stage in the valid/retry handshake fabric.

Parameters:
- Size, 8, operand/result width in bits.
- N, 4, number of requesters (2..8).
- TagW, $clog2(N), width of the internal requester tag.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- inp_a  input  N*Size  operand a of requester i at bits [i*Size +: Size].
- inp_b  input  N*Size  operand b of requester i at bits [i*Size +: Size].
- inp_valid  input  N  per-requester operand valid.
- inp_retry  output  N  per-requester back-pressure.
- sum  output  Size  buffer-head sum (shared result bus).
- sum_tag  output  TagW  requester index of the buffer head.
- sum_valid  output  N  one-hot result valid; bit sum_tag set when the head is valid.
- sum_retry  input  N  per-requester result back-pressure.

Behaviour:
- Handshake:
  - A transfer occurs on a channel in a cycle where valid=1 and retry=0.
  - A sender holding valid keeps its data stable until the transfer occurs.
- can_accept = (buffer count < 2), computed from registered count only.
  - There is no combinational path from sum_retry to inp_retry.
  - count==2 blocks a push even if the head pops in the same cycle.
- Arbitration (combinational):
  - When can_accept=1, grant the first i with inp_valid[i]=1, searching ptr, ptr+1, … mod N.
  - When can_accept=0, grant nothing.
- inp_retry[i] = !(grant[i]). Non-granted or non-valid requesters see retry=1.
- Pointer update: on a push from requester g, ptr <= (g+1) mod N. With no push, ptr holds.
- Arithmetic: sum_next = inp_a[g] + inp_b[g], truncated to Size bits (mod 2^Size), carry discarded.
- Push writes {g, sum_next} at the tail.
- Pop occurs when count>0 and sum_retry[head_tag]=0.
- Push and pop in the same cycle: count unchanged and FIFO order preserved.
- Latency: operands accepted at edge k are visible on sum/sum_valid after edge k.
- Throughput: 1 result/cycle when sinks never retry.
- Ordering: results emerge in grant order. Head-of-line blocking is intended; a retried head stalls all requesters' results.
- Outputs:
  - sum_valid = count>0 ? (1 << head_tag) : 0.
  - sum and sum_tag show the head entry; they are don't-care (hold last value) when empty.
- Reset (asynchronous assert, synchronous deassert assumed at the board level):
  - ptr=0, count=0, sum_valid=0, sum=0, sum_tag=0.
  - inp_retry = all 1 while reset=0.
  - Reset asserted mid-operation discards buffered entries without popping them.
- Fairness: a continuously valid requester is granted within N pushes.

Decomposition:
- Package join_arb_pkg:
  - Default Size/N constants.
  - Tag-width function.
  - Entry struct {tag, sum}.
- Sub-module join_arb_buf: 2-entry registered valid/retry buffer.
  - Push side: din, dinValid, dinRetry=(count==2).
  - Pop side: q, qValid, qRetry.
  - Asynchronous active-low reset.
- The arbiter and adder live in the top module.

Test Plan:
- Single request:
  - Stimulus: req1 a=8'h10, b=8'h22; sinks idle.
  - Response: inp_retry[1]=0 at that cycle; next cycle sum=8'h32, sum_tag=1, sum_valid=4'b0010; ptr becomes 2.
- Wrap-around:
  - Stimulus: req0 a=8'hF0, b=8'h20.
  - Response: sum=8'h10, no carry output.
- Round-robin:
  - Stimulus: all 4 valid continuously; sinks idle.
  - Response: grants 0,1,2,3,0,… one per cycle; results tagged in the same order, each 1 cycle after acceptance.
- Back-pressure:
  - Stimulus: sum_retry=4'b1111 with req2 and req3 valid.
  - Response: two pushes (tags 2,3), then inp_retry=all 1 and count=2.
  - Then drop sum_retry[2] only: head pops; the next cycle can accept again; tag-3 result stays at head until sum_retry[3]=0.
- Simultaneous push/pop:
  - Stimulus: count=1, head sink ready, req0 valid.
  - Response: count stays 1; the old head is delivered, and req0's result appears the next cycle.
- Reset mid-stream:
  - Stimulus: count=2; drive reset=0 asynchronously between edges.
  - Response: sum_valid=0 immediately, inp_retry=all 1; after release, the first grant starts from requester 0.
